// File: rtl/freq_meter.sv
// freq_meter: counts sig_in rising edges over GATE_CYCLES-cycle windows.
// Define FREQ_METER_SATURATE_EN to saturate the edge counter and report overflow.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sig_in,
    input  logic        enable,
    output logic [31:0] freq_out,
    output logic        valid,
    output logic        busy,
    output logic        overflow
);
    typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;
    localparam logic [31:0]      LAST = 32'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX  = '1;
    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q, edge_det, window_done, sat_hit;
    logic [31:0]      gate_cnt_q, gate_cnt_d, freq_q, freq_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, edge_nxt;
    logic             ovf_q, ovf_d;

    assign edge_det    = s2_q & ~s3_q;
    assign window_done = (state_q == GATE) && enable && (gate_cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            {s1_q, s2_q, s3_q} <= 3'b000;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            {s1_q, s2_q, s3_q} <= {sig_in, s1_q, s2_q};
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d = (state_q == GATE) ? (!enable ? IDLE : window_done ? LATCH : GATE)
                                    : (enable ? GATE : IDLE);
    end

`ifdef FREQ_METER_SATURATE_EN
    assign edge_nxt = (edge_cnt_q == MAX) ? edge_cnt_q : edge_cnt_q + {{(CNT_W-1){1'b0}}, edge_det};
    assign sat_hit  = edge_nxt == MAX;
`else
    assign edge_nxt = edge_cnt_q + {{(CNT_W-1){1'b0}}, edge_det};
    assign sat_hit  = 1'b0;
`endif

    // Counters are held at zero outside GATE, so every window starts clean.
    always_comb begin
        gate_cnt_d = (state_q == GATE) ? gate_cnt_q + 32'd1 : '0;
        edge_cnt_d = (state_q == GATE) ? edge_nxt : '0;
        freq_d     = window_done ? 32'(edge_nxt) : freq_q;
        ovf_d      = window_done ? sat_hit : ovf_q;
    end

    always_comb begin
        busy     = state_q == GATE;
        valid    = state_q == LATCH;
        freq_out = freq_q;
        overflow = ovf_q;
    end
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: randomized and directed checks of freq_meter against a window-sum model.
module tb_freq_meter;
    localparam int G = 100;
`ifdef FREQ_METER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic clk = 1'b0, reset_n = 1'b0, sig_in = 1'b0, enable = 1'b0;
    logic [31:0] freq_out, freq4;
    logic valid, busy, overflow, valid4, busy4, ovf4;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(32)) u_dut (
        .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .enable(enable),
        .freq_out(freq_out), .valid(valid), .busy(busy), .overflow(overflow)
    );
    freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .enable(enable),
        .freq_out(freq4), .valid(valid4), .busy(busy4), .overflow(ovf4)
    );

    int n_cmp = 0, n_err = 0, cyc = 0;
    int sig_mode = 0, per = 10;
    int mode = 0, pos = 0, sum = 0;
    longint exp_freq = 0, exp_freq4 = 0;
    bit exp_ovf4 = 1'b0;
    bit hist[$] = '{1'b0, 1'b0, 1'b0};

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Window model: raw edge total over the gate window, then width/saturation applied.
    task automatic model_step();
        bit e;
        e = hist[1] & ~hist[2];
        if (!reset_n) begin
            mode = 0; pos = 0; sum = 0;
            exp_freq = 0; exp_freq4 = 0; exp_ovf4 = 1'b0;
            hist = '{1'b0, 1'b0, 1'b0};
        end else begin
            hist.push_front(sig_in);
            void'(hist.pop_back());
            if (mode == 1) begin
                if (!enable) mode = 0;
                else begin
                    sum += int'(e);
                    if (pos == G - 1) begin
                        mode = 2;
                        exp_freq = sum;
                        exp_freq4 = SAT ? ((sum > 15) ? 15 : sum) : sum % 16;
                        exp_ovf4 = SAT && sum >= 15;
                    end else pos++;
                end
            end else if (enable) begin
                mode = 1; pos = 0; sum = 0;
            end else mode = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        check("freq_out", freq_out, exp_freq);
        check("valid", valid, mode == 2);
        check("busy", busy, mode == 1);
        check("overflow", overflow, 0);
        check("freq_out_w4", freq4, exp_freq4);
        check("valid_w4", valid4, mode == 2);
        check("busy_w4", busy4, mode == 1);
        check("overflow_w4", ovf4, exp_ovf4);
        cyc++;
        case (sig_mode)
            0: sig_in = 1'b0;
            1: sig_in = 1'b1;
            2: sig_in = (cyc % per) < per / 2;
            default: sig_in = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic wait_valid(input int bound, output int steps);
        steps = 0;
        do begin
            step();
            steps++;
        end while (!valid && steps < bound);
        check("valid_timeout", valid, 1);
    endtask

    initial begin
        int n, nv;
        repeat (3) step();
        check("rst_freq", freq_out, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        // Test 1: period-10 square wave
        reset_n = 1'b1; enable = 1'b1; sig_mode = 2; per = 10;
        wait_valid(300, n);
        wait_valid(300, n);
        check("t1_gap", n, 101);
        check("t1_freq", freq_out, 10);
        check("t1_ovf", overflow, 0);
        // Test 2: held low, then held high
        sig_mode = 0;
        wait_valid(300, n);
        wait_valid(300, n);
        check("t2_low", freq_out, 0);
        sig_mode = 1;
        wait_valid(300, n);
        wait_valid(300, n);
        check("t2_high", freq_out, 0);
        check("t2_gap", n, 101);
        // Test 3: abort mid-window
        sig_mode = 2; per = 5;
        wait_valid(300, n);
        wait_valid(300, n);
        check("t3_first", freq_out, 20);
        repeat (50) step();
        enable = 1'b0;
        step();
        check("t3_busy", busy, 0);
        nv = 0;
        repeat (150) begin
            step();
            if (valid) nv++;
        end
        check("t3_novalid", nv, 0);
        check("t3_hold", freq_out, 20);
        // Test 4: 50 edges into a 4-bit counter
        enable = 1'b1; per = 2;
        wait_valid(300, n);
        wait_valid(300, n);
        check("t4_freq32", freq_out, 50);
        check("t4_freq4", freq4, SAT ? 15 : 2);
        check("t4_ovf4", ovf4, SAT ? 1 : 0);
        // Test 5: one-cycle reset mid-GATE
        per = 5;
        wait_valid(300, n);
        repeat (30) step();
        reset_n = 1'b0;
        step();
        check("t5_freq", freq_out, 0);
        check("t5_busy", busy, 0);
        check("t5_valid", valid, 0);
        check("t5_freq4", freq4, 0);
        reset_n = 1'b1;
        wait_valid(300, n);
        check("t5_len", n, 101);
        // Test 6: single edge detected in final GATE cycle, then in LATCH
        sig_mode = 0;
        wait_valid(300, n);
        wait_valid(300, n);
        repeat (98) step();
        sig_in = 1'b1; sig_mode = 1;
        wait_valid(300, n);
        check("t6_lat", n, 3);
        check("t6_final", freq_out, 1);
        sig_in = 1'b0; sig_mode = 0;
        wait_valid(300, n);
        repeat (99) step();
        sig_in = 1'b1; sig_mode = 1;
        wait_valid(300, n);
        check("t6_before", freq_out, 0);
        wait_valid(300, n);
        check("t6_after", freq_out, 0);
        // Randomized segments
        for (int s = 0; s < 40; s++) begin
            sig_mode = $urandom_range(0, 3);
            per = $urandom_range(2, 16);
            for (int i = 0; i < int'($urandom_range(20, 250)); i++) begin
                step();
                if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
                else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
                reset_n = $urandom_range(0, 499) != 0;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
